// File: rtl/vga_pic_sprite.sv
// Pixel generator: draws a movable solid sprite on a flat background.
// Four debounced active-low buttons move it at frame end, with optional hold-to-repeat.
module vga_pic_sprite #(
  parameter int          H_VALID       = 640,
  parameter int          V_VALID       = 480,
  parameter int          BOX_W         = 64,
  parameter int          BOX_H         = 64,
  parameter int          STEP          = 8,
  parameter int          INIT_X        = 288,
  parameter int          INIT_Y        = 208,
  parameter int          DEB_CYCLES    = 250000,
  parameter int          REPEAT_FRAMES = 8,
  parameter logic [15:0] BG_COLOR      = 16'h0000,
  parameter logic [15:0] BOX_COLOR     = 16'hF800
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  output logic [15:0] pix_data,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y
);

  localparam int          DW     = $clog2(DEB_CYCLES + 1);
  localparam int          RW     = (REPEAT_FRAMES < 2) ? 1 : $clog2(REPEAT_FRAMES);
  localparam logic [10:0] X_MAX  = 11'(H_VALID - BOX_W);
  localparam logic [10:0] Y_MAX  = 11'(V_VALID - BOX_H);
  localparam logic [10:0] STEP11 = 11'(STEP);

  // Button order in every vector: 0 up, 1 down, 2 left, 3 right.
  logic [3:0]    raw, sync1, sync2, deb, pend, press, rep_evt;
  logic [DW-1:0] deb_cnt [4];
  logic [RW-1:0] rep_cnt [4];
  logic          frame_end;
  logic          mv_up, mv_dn, mv_lt, mv_rt;
  logic [10:0]   x11, y11, nxt_x, nxt_y;
  logic          in_box;

  assign raw       = {right, left, down, up};
  assign frame_end = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A level is accepted only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      deb <= 4'hF;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    press   = 4'b0000;
    rep_evt = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      press[i]   = (sync2[i] != deb[i]) && (deb_cnt[i] == DW'(DEB_CYCLES - 1)) && !sync2[i];
      rep_evt[i] = (REPEAT_FRAMES != 0) && frame_end && !deb[i] &&
                   (rep_cnt[i] == RW'(REPEAT_FRAMES - 1));
    end
  end

  // Frame-end counter per held button; clears on release.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 4; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (deb[i]) begin
          rep_cnt[i] <= '0;
        end else if (frame_end) begin
          rep_cnt[i] <= rep_evt[i] ? '0 : rep_cnt[i] + 1'b1;
        end else begin
          rep_cnt[i] <= rep_cnt[i];
        end
      end
    end
  end

  // Events arriving on the frame-end cycle survive into the next frame.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend <= 4'b0000;
    end else begin
      pend <= (frame_end ? 4'b0000 : pend) | press | rep_evt;
    end
  end

  assign mv_up = pend[0] & ~pend[1];
  assign mv_dn = pend[1] & ~pend[0];
  assign mv_lt = pend[2] & ~pend[3];
  assign mv_rt = pend[3] & ~pend[2];
  assign x11   = {1'b0, box_x};
  assign y11   = {1'b0, box_y};

  always_comb begin
    if (mv_up) begin
      nxt_y = (y11 < STEP11) ? 11'd0 : y11 - STEP11;
    end else if (mv_dn) begin
      nxt_y = (y11 + STEP11 > Y_MAX) ? Y_MAX : y11 + STEP11;
    end else begin
      nxt_y = y11;
    end
    if (mv_lt) begin
      nxt_x = (x11 < STEP11) ? 11'd0 : x11 - STEP11;
    end else if (mv_rt) begin
      nxt_x = (x11 + STEP11 > X_MAX) ? X_MAX : x11 + STEP11;
    end else begin
      nxt_x = x11;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      box_x <= 10'(INIT_X);
      box_y <= 10'(INIT_Y);
    end else if (frame_end) begin
      box_x <= nxt_x[9:0];
      box_y <= nxt_y[9:0];
    end else begin
      box_x <= box_x;
      box_y <= box_y;
    end
  end

  assign in_box = (pix_x >= box_x) && ({1'b0, pix_x} < x11 + 11'(BOX_W)) &&
                  (pix_y >= box_y) && ({1'b0, pix_y} < y11 + 11'(BOX_H));

  // Registered pixel colour; blanking area forced black.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_data <= 16'h0000;
    end else if ((pix_x >= 10'(H_VALID)) || (pix_y >= 10'(V_VALID))) begin
      pix_data <= 16'h0000;
    end else if (in_box) begin
      pix_data <= BOX_COLOR;
    end else begin
      pix_data <= BG_COLOR;
    end
  end

endmodule

// File: tb/tb_vga_pic_sprite.sv
// Scoreboard bench for vga_pic_sprite; a second instance starts near the clamp limits.
module tb_vga_pic_sprite;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  px = 10'd0;
  logic [9:0]  py = 10'd0;
  logic [3:0]  btn = 4'hF;   // 0 up, 1 down, 2 left, 3 right
  logic [15:0] pd1, pd2;
  logic [9:0]  bx1, by1, bx2, by2;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_pic_sprite #(.DEB_CYCLES(4), .REPEAT_FRAMES(8)) dut (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(px), .pix_y(py),
    .up(btn[0]), .down(btn[1]), .left(btn[2]), .right(btn[3]),
    .pix_data(pd1), .box_x(bx1), .box_y(by1)
  );

  vga_pic_sprite #(.DEB_CYCLES(4), .REPEAT_FRAMES(8), .INIT_X(572), .INIT_Y(4)) dut2 (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(px), .pix_y(py),
    .up(btn[0]), .down(btn[1]), .left(btn[2]), .right(btn[3]),
    .pix_data(pd2), .box_x(bx2), .box_y(by2)
  );

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", tag, act, exp);
    end
  endtask

  task automatic pop_check(input logic [15:0] act);
    exp_t e;
    e = sbq.pop_front();
    check_val(e.tag, act, e.exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                     input logic [15:0] exp);
    @(posedge clk);
    #1;
    px = x;
    py = y;
    sbq.push_back('{tag, exp});
    @(posedge clk);
    #1;
    pop_check(pd1);
  endtask

  task automatic box_chk(input string tag, input int ex1, input int ey1,
                         input int ex2, input int ey2);
    sbq.push_back('{{tag, "_x1"}, 16'(ex1)});
    sbq.push_back('{{tag, "_y1"}, 16'(ey1)});
    sbq.push_back('{{tag, "_x2"}, 16'(ex2)});
    sbq.push_back('{{tag, "_y2"}, 16'(ey2)});
    pop_check({6'd0, bx1});
    pop_check({6'd0, by1});
    pop_check({6'd0, bx2});
    pop_check({6'd0, by2});
  endtask

  task automatic frame_end();
    @(posedge clk);
    #1;
    px = 10'd639;
    py = 10'd479;
    @(posedge clk);
    #1;
    px = 10'd0;
    py = 10'd0;
  endtask

  task automatic press(input int idx, input int n);
    @(posedge clk);
    #1;
    btn[idx] = 1'b0;
    idle(n);
    btn[idx] = 1'b1;
    idle(20);
  endtask

  initial begin
    idle(3);
    check_val("rst_pix", pd1, 16'h0000);
    box_chk("rst", 288, 208, 572, 4);
    rst_n = 1'b1;
    idle(2);

    pix("pix_origin", 10'd288, 10'd208, 16'hF800);
    pix("pix_left_out", 10'd287, 10'd208, 16'h0000);
    pix("pix_blank", 10'd700, 10'd10, 16'h0000);
    pix("pix_corner", 10'd351, 10'd271, 16'hF800);
    pix("pix_right_out", 10'd352, 10'd208, 16'h0000);
    pix("pix_below_out", 10'd288, 10'd272, 16'h0000);
    pix("pix_vblank", 10'd300, 10'd480, 16'h0000);
    pix("pix_dut2_area", 10'd572, 10'd4, 16'h0000);
    check_val("pix_dut2", pd2, 16'hF800);

    // single moves; dut2 exercises the clamps
    press(0, 100);
    box_chk("up_before", 288, 208, 572, 4);
    frame_end();
    box_chk("up_after", 288, 200, 572, 0);
    press(3, 100);
    frame_end();
    box_chk("right", 296, 200, 576, 0);
    press(0, 30);
    frame_end();
    box_chk("up_clamp", 296, 192, 576, 0);
    press(3, 30);
    frame_end();
    box_chk("right_clamp", 304, 192, 576, 0);

    pix("pix_moved", 10'd304, 10'd192, 16'hF800);
    pix("pix_moved_l", 10'd303, 10'd192, 16'h0000);
    pix("pix_moved_c", 10'd367, 10'd255, 16'hF800);
    pix("pix_moved_r", 10'd368, 10'd255, 16'h0000);

    for (int g = 0; g < 10; g++) begin
      btn[2] = 1'b0;
      idle(3);
      btn[2] = 1'b1;
      idle(10);
    end
    frame_end();
    box_chk("glitch_f1", 304, 192, 576, 0);
    idle(5);
    frame_end();
    box_chk("glitch_f2", 304, 192, 576, 0);

    // hold down for 20 frames: steps land on frame ends 1, 9, 17
    btn[1] = 1'b0;
    idle(10);
    for (int k = 1; k <= 20; k++) begin
      int ey;
      ey = 192 + 8 * ((k >= 1) + (k >= 9) + (k >= 17));
      idle(5);
      frame_end();
      box_chk($sformatf("repeat_f%0d", k), 304, ey, 576, ey - 192);
    end
    btn[1] = 1'b1;
    idle(10);
    for (int k = 0; k < 10; k++) begin
      idle(5);
      frame_end();
    end
    box_chk("repeat_released", 304, 216, 576, 24);

    press(0, 20);
    press(1, 20);
    frame_end();
    box_chk("opposing", 304, 216, 576, 24);
    press(0, 20);
    press(2, 20);
    frame_end();
    box_chk("up_left", 296, 208, 568, 16);

    // reset with a move pending: it must be dropped
    pix("pix_pre_rst", 10'd300, 10'd215, 16'hF800);
    press(0, 20);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("rst_async_pix", pd1, 16'h0000);
    box_chk("rst_async", 288, 208, 572, 4);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    frame_end();
    box_chk("rst_discard", 288, 208, 572, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
